pixel_column_reader: RTL and testbench

- Byte-stream front end that reads raw RGB image data (R, G, B byte order, one byte per beat, the same layout the pipeline dumps as image.raw).
- Assembles each group of PIPELINE_HEIGHT consecutive pixels into one PixelArray column and hands it to the edge-detection pipeline through a valid/ready interface.
- Replaces the free-running pixel generator stage when real image data drives the pipeline.

---
 rtl/pixel_pkg.sv | 14 +
 rtl/pixel_byte_sequencer.sv | 54 +++++
 rtl/pixel_column_reader.sv | 83 ++++++++
 tb/tb_pixel_column_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Pixel and column types shared by the pixel reader, the edge-detection pipeline
// and the file-writer bench.
package pixel_pkg;
  localparam int PipelineHeight  = 5;
  localparam int BYTES_PER_PIXEL = 3;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } Pixel;

  typedef Pixel [0:PipelineHeight-1] PixelArray;
endpackage

// File: rtl/pixel_byte_sequencer.sv
// Tracks the byte phase (R/G/B) and pixel index within a column, and flags
// column completion and resyncs that drop a partial column.
module pixel_byte_sequencer
  import pixel_pkg::*;
#(
  parameter int PIPELINE_HEIGHT = PipelineHeight,
  parameter int IDX_W           = (PIPELINE_HEIGHT > 1) ? $clog2(PIPELINE_HEIGHT) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             accept,
  input  logic             sync,
  output logic [IDX_W-1:0] wr_index,
  output logic [1:0]       wr_phase,
  output logic             column_done,
  output logic             sync_error
);
  logic [1:0]       phase;
  logic [IDX_W-1:0] index;
  logic             at_start;
  logic             last_phase;
  logic             last_index;

  always_comb begin
    at_start    = (phase == 2'd0) && (index == '0);
    last_phase  = (phase == 2'(BYTES_PER_PIXEL - 1));
    last_index  = (index == IDX_W'(PIPELINE_HEIGHT - 1));
    // A sync byte is always the red byte of pixel 0, whatever the counters say.
    wr_index    = sync ? '0 : index;
    wr_phase    = sync ? 2'd0 : phase;
    column_done = accept && !sync && last_phase && last_index;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= 2'd0;
      index      <= '0;
      sync_error <= 1'b0;
    end else begin
      sync_error <= accept && sync && !at_start;
      if (accept) begin
        if (sync) begin
          phase <= 2'd1;
          index <= '0;
        end else if (last_phase) begin
          phase <= 2'd0;
          index <= last_index ? '0 : index + 1'b1;
        end else begin
          phase <= phase + 2'd1;
        end
      end
    end
  end
endmodule

// File: rtl/pixel_column_reader.sv
// Assembles raw RGB bytes into PixelArray columns behind a one-column shadow
// buffer and presents them on a valid/ready output register.
module pixel_column_reader
  import pixel_pkg::*;
#(
  parameter int PIPELINE_HEIGHT = PipelineHeight,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_sync,
  output logic                   in_ready,
  output PixelArray              out_pixels,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sync_error,
  output logic [COUNT_WIDTH-1:0] column_count
);
  localparam int IDX_W = (PIPELINE_HEIGHT > 1) ? $clog2(PIPELINE_HEIGHT) : 1;

  PixelArray        shadow_p0;
  PixelArray        shadow_next;
  logic             shadow_full;
  logic             accept;
  logic             column_done;
  logic             load;
  logic [IDX_W-1:0] wr_index;
  logic [1:0]       wr_phase;

  assign in_ready = !shadow_full || out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  pixel_byte_sequencer #(
    .PIPELINE_HEIGHT(PIPELINE_HEIGHT),
    .IDX_W          (IDX_W)
  ) u_sequencer (
    .clock      (clock),
    .reset_n    (reset_n),
    .accept     (accept),
    .sync       (in_sync),
    .wr_index   (wr_index),
    .wr_phase   (wr_phase),
    .column_done(column_done),
    .sync_error (sync_error)
  );

  always_comb begin
    shadow_next = shadow_p0;
    if (accept) begin
      case (wr_phase)
        2'd0:    shadow_next[wr_index].red   = in_byte;
        2'd1:    shadow_next[wr_index].green = in_byte;
        default: shadow_next[wr_index].blue  = in_byte;
      endcase
    end
  end

  // A held full shadow always leaves before the next column can write into it,
  // so a full shadow and a completing column never coincide.
  assign load = (shadow_full || column_done) && (!out_valid || out_ready);

  // Stage p0: shadow column under assembly
  always_ff @(posedge clock) begin
    shadow_p0 <= shadow_next;
  end

  // Stage p1: output register and handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_pixels   <= '0;
      out_valid    <= 1'b0;
      shadow_full  <= 1'b0;
      column_count <= '0;
    end else begin
      if (load) out_pixels <= shadow_full ? shadow_p0 : shadow_next;
      out_valid   <= load || (out_valid && !out_ready);
      shadow_full <= (shadow_full || column_done) && !load;
      if (out_valid && out_ready) column_count <= column_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_column_reader.sv
// Randomized bench for pixel_column_reader against a queue-based column model.
module tb_pixel_column_reader;
  import pixel_pkg::*;

  localparam int CW        = 8;
  localparam int COL_BYTES = PipelineHeight * BYTES_PER_PIXEL;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          in_valid = 1'b0;
  logic          in_sync = 1'b0;
  logic          in_ready;
  PixelArray     out_pixels;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          sync_error;
  logic [CW-1:0] column_count;

  pixel_column_reader #(.PIPELINE_HEIGHT(PipelineHeight), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_sync(in_sync), .in_ready(in_ready), .out_pixels(out_pixels),
    .out_valid(out_valid), .out_ready(out_ready), .sync_error(sync_error),
    .column_count(column_count)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  PixelArray   exp_q[$];
  logic [7:0]  part[$];
  int          mcount = 0;
  bit          err_exp = 0;
  int          err_seen = 0;
  PixelArray   last_deliv = '0;
  PixelArray   samp_pixels;
  logic        samp_valid;
  logic [CW-1:0] samp_count;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic PixelArray mk_col(input logic [7:0] q[$]);
    PixelArray c;
    for (int p = 0; p < PipelineHeight; p++)
      c[p] = {q[3*p], q[3*p+1], q[3*p+2]};
    return c;
  endfunction

  task automatic step(input bit v, input logic [7:0] b, input bit s, input bit r, output bit acc);
    bit exp_ready;
    bit hs;
    @(negedge clock);
    in_valid = v; in_byte = b; in_sync = s; out_ready = r;
    #1;
    exp_ready = (exp_q.size() < 2) || r;
    check("in_ready", 128'(in_ready), 128'(exp_ready));
    check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    check("sync_error", 128'(sync_error), 128'(err_exp));
    check("column_count", 128'(column_count), 128'(mcount[CW-1:0]));
    if (exp_q.size() > 0) check("out_pixels", 128'(out_pixels), 128'(exp_q[0]));
    samp_pixels = out_pixels; samp_valid = out_valid; samp_count = column_count;
    if (sync_error) err_seen++;
    hs  = (exp_q.size() > 0) && r;
    acc = v && exp_ready;
    if (hs) begin
      last_deliv = exp_q.pop_front();
      mcount++;
    end
    err_exp = 1'b0;
    if (acc) begin
      if (s) begin
        if (part.size() != 0) err_exp = 1'b1;
        part.delete();
      end
      part.push_back(b);
      if (part.size() == COL_BYTES) begin
        exp_q.push_back(mk_col(part));
        part.delete();
      end
    end
  endtask

  task automatic feed(input logic [7:0] b, input bit s, input bit r);
    bit acc;
    for (int n = 0; n < 50; n++) begin
      step(1'b1, b, s, r, acc);
      if (acc) return;
    end
    check("feed_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r, acc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_count", 128'(column_count), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_sync_error", 128'(sync_error), 128'(0));
    check("rst_pixels", 128'(out_pixels), 128'(0));
    exp_q.delete(); part.delete(); mcount = 0; err_exp = 0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit         acc;
    int         idx;
    int         e0;
    int         c0;
    logic [7:0] q[$];
    logic [7:0] vals[45];

    do_reset();

    // Single column, consumer always ready
    for (int i = 1; i <= COL_BYTES; i++) feed(8'(i), 1'b0, 1'b1);
    idle(1, 1'b1);
    check("t1_valid", 128'(samp_valid), 128'(1));
    check("t1_pix0", 128'(samp_pixels[0]), 128'(24'h010203));
    check("t1_pix4", 128'(samp_pixels[4]), 128'(24'h0D0E0F));
    idle(1, 1'b1);
    check("t1_count", 128'(samp_count), 128'(1));

    // Stalled consumer: two columns held, then drain
    for (int i = 0; i < 45; i++) vals[i] = 8'(8'h40 + i);
    idx = 0;
    for (int n = 0; n < 40; n++) begin
      step(1'b1, vals[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("stall_accepted", 128'(idx), 128'(30));
    step(1'b1, vals[idx], 1'b0, 1'b1, acc);
    check("drain_first_accept", 128'(acc), 128'(1));
    if (acc) idx++;
    for (int n = 0; n < 200 && idx < 45; n++) begin
      step(1'b1, vals[idx], 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    idle(3, 1'b1);
    check("stall_count", 128'(samp_count), 128'(4));

    // Resync mid-column drops the partial column
    e0 = err_seen;
    c0 = mcount;
    for (int i = 0; i < 7; i++) feed(8'(8'h10 + i), 1'b0, 1'b1);
    feed(8'hAA, 1'b1, 1'b1);
    q.delete(); q.push_back(8'hAA);
    for (int i = 0; i < 14; i++) begin
      feed(8'(8'h20 + i), 1'b0, 1'b1);
      q.push_back(8'(8'h20 + i));
    end
    idle(3, 1'b1);
    check("sync_err_once", 128'(err_seen - e0), 128'(1));
    check("sync_cols", 128'(mcount - c0), 128'(1));
    check("sync_red", 128'(last_deliv[0].red), 128'(8'hAA));
    check("sync_col", 128'(last_deliv), 128'(mk_col(q)));

    // Sync on every column start is never an error
    do_reset();
    e0 = err_seen;
    for (int c = 0; c < 100; c++)
      for (int i = 0; i < COL_BYTES; i++) feed(8'($urandom), (i == 0), 1'b1);
    idle(3, 1'b1);
    check("aligned_no_err", 128'(err_seen - e0), 128'(0));
    check("aligned_count", 128'(samp_count), 128'(100));

    // Reset mid-column while a column is held
    for (int i = 0; i < COL_BYTES + 9; i++) feed(8'($urandom), 1'b0, 1'b0);
    check("pre_reset_valid", 128'(out_valid), 128'(1));
    do_reset();
    q.delete();
    for (int i = 0; i < COL_BYTES; i++) begin
      q.push_back(8'(8'hC0 + i));
      feed(8'(8'hC0 + i), 1'b0, 1'b1);
    end
    idle(2, 1'b1);
    check("post_reset_col", 128'(last_deliv), 128'(mk_col(q)));
    check("post_reset_count", 128'(samp_count), 128'(1));

    // Random traffic up to the counter wrap
    do_reset();
    for (int n = 0; n < 40000 && mcount < (1 << CW) - 1; n++)
      step(($urandom % 10) < 7, 8'($urandom), ($urandom % 50) == 0,
           ($urandom % 10) < 6, acc);
    check("reached_max", 128'(mcount), 128'((1 << CW) - 1));
    for (int n = 0; n < 200 && mcount < (1 << CW); n++)
      step(1'b1, 8'($urandom), 1'b0, 1'b1, acc);
    idle(1, 1'b0);
    check("wrap_count", 128'(samp_count), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
